// File: rtl/lcm_pkg.sv
// Shared constants, state encodings and character helpers for the HD44780 time writer.
package lcm_pkg;

  localparam logic [7:0] CMD_FUNC_8BIT = 8'h38;
  localparam logic [7:0] CMD_CLEAR     = 8'h01;
  localparam logic [7:0] CMD_ENTRY     = 8'h06;
  localparam logic [7:0] CMD_DISP_ON   = 8'h0C;
  localparam logic [7:0] CMD_LINE1     = 8'h80;
  localparam logic [7:0] CMD_LINE2     = 8'hC0;

  localparam logic [7:0] CH_SPACE   = 8'h20;
  localparam logic [7:0] CH_COLON   = 8'h3A;
  localparam logic [7:0] CH_UNKNOWN = 8'h3F;

  localparam logic [0:15][7:0] BANNER    = "  24-Hr. Clock  ";
  localparam logic [0:3][7:0]  INIT_CMDS = {CMD_FUNC_8BIT, CMD_CLEAR, CMD_ENTRY, CMD_DISP_ON};

  typedef enum logic [2:0] {
    ST_POWERUP,
    ST_INIT,
    ST_BANNER,
    ST_LINE2,
    ST_IDLE
  } lcm_state_e;

  typedef enum logic [1:0] {
    WR_IDLE,
    WR_SETUP,
    WR_HIGH,
    WR_WAIT
  } wr_state_e;

  function automatic logic [7:0] bcd_to_ascii(input logic [3:0] nib);
    return (nib <= 4'd9) ? {4'h3, nib} : CH_UNKNOWN;
  endfunction

  // Character at column pos of "    HH:MM:SS    ".
  function automatic logic [7:0] line2_char(input logic [3:0] pos, input logic [23:0] t);
    logic [7:0] c;
    c = CH_SPACE;
    case (pos)
      4'd4:        c = bcd_to_ascii(t[23:20]);
      4'd5:        c = bcd_to_ascii(t[19:16]);
      4'd7:        c = bcd_to_ascii(t[15:12]);
      4'd8:        c = bcd_to_ascii(t[11:8]);
      4'd10:       c = bcd_to_ascii(t[7:4]);
      4'd11:       c = bcd_to_ascii(t[3:0]);
      4'd6, 4'd9:  c = CH_COLON;
      default:     c = CH_SPACE;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/lcm_byte_writer.sv
// One LCD byte transaction: RS/DATA setup, registered EN pulse, then a per-command wait.
module lcm_byte_writer
  import lcm_pkg::*;
#(
  parameter int unsigned SETUP_CYC      = 8,
  parameter int unsigned EN_HIGH_CYC    = 50,
  parameter int unsigned CMD_WAIT_CYC   = 5000,
  parameter int unsigned CLEAR_WAIT_CYC = 200_000
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       start,
  input  logic       rs,
  input  logic [7:0] data,
  input  logic       long_wait,
  output logic       busy,
  output logic       done,
  output logic       LCM_RS,
  output logic       LCM_EN,
  output logic [7:0] LCM_DATA
);

  localparam int unsigned MAX_SH  = (SETUP_CYC > EN_HIGH_CYC) ? SETUP_CYC : EN_HIGH_CYC;
  localparam int unsigned MAX_W   = (CMD_WAIT_CYC > CLEAR_WAIT_CYC) ? CMD_WAIT_CYC : CLEAR_WAIT_CYC;
  localparam int unsigned MAX_ALL = (MAX_SH > MAX_W) ? MAX_SH : MAX_W;
  localparam int          CNT_W   = $clog2(MAX_ALL + 1);

  localparam logic [CNT_W-1:0] SETUP_LAST = CNT_W'(SETUP_CYC - 1);
  localparam logic [CNT_W-1:0] HIGH_LAST  = CNT_W'(EN_HIGH_CYC - 1);
  localparam logic [CNT_W-1:0] CMD_LAST   = CNT_W'(CMD_WAIT_CYC - 1);
  localparam logic [CNT_W-1:0] CLEAR_LAST = CNT_W'(CLEAR_WAIT_CYC - 1);

  wr_state_e        st_q, st_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, wait_last;
  logic             en_q, en_d, rs_q, rs_d, long_q, long_d;
  logic [7:0]       data_q, data_d;

  // Handshake: start is accepted when idle or in the done cycle (last wait
  // cycle), so chained bytes launch back to back; rs/data/long_wait are
  // sampled only on that accepting edge.
  always_comb begin
    st_d      = st_q;
    cnt_d     = cnt_q;
    en_d      = en_q;
    rs_d      = rs_q;
    data_d    = data_q;
    long_d    = long_q;
    wait_last = long_q ? CLEAR_LAST : CMD_LAST;
    busy      = (st_q != WR_IDLE);
    done      = (st_q == WR_WAIT) && (cnt_q == wait_last);
    case (st_q)
      WR_SETUP:
        if (cnt_q == SETUP_LAST) begin
          st_d  = WR_HIGH;
          cnt_d = '0;
          en_d  = 1'b1;
        end else cnt_d = cnt_q + CNT_W'(1);
      WR_HIGH:
        if (cnt_q == HIGH_LAST) begin
          st_d  = WR_WAIT;
          cnt_d = '0;
          en_d  = 1'b0;
        end else cnt_d = cnt_q + CNT_W'(1);
      WR_WAIT:
        if (done) st_d = WR_IDLE;
        else cnt_d = cnt_q + CNT_W'(1);
      default: ;
    endcase
    if (start && (!busy || done)) begin
      st_d   = WR_SETUP;
      cnt_d  = '0;
      en_d   = 1'b0;
      rs_d   = rs;
      data_d = data;
      long_d = long_wait;
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      st_q   <= WR_IDLE;
      cnt_q  <= '0;
      en_q   <= 1'b0;
      rs_q   <= 1'b0;
      data_q <= 8'h00;
      long_q <= 1'b0;
    end else begin
      st_q   <= st_d;
      cnt_q  <= cnt_d;
      en_q   <= en_d;
      rs_q   <= rs_d;
      data_q <= data_d;
      long_q <= long_d;
    end
  end

  assign LCM_RS   = rs_q;
  assign LCM_EN   = en_q;
  assign LCM_DATA = data_q;

endmodule

// File: rtl/lcm_time_writer.sv
// Sequencer: power-up wait, LCD init, line-1 banner, then line-2 time rewrites on each update strobe.
module lcm_time_writer
  import lcm_pkg::*;
#(
  parameter int unsigned POWERUP_CYC    = 2_000_000,
  parameter int unsigned SETUP_CYC      = 8,
  parameter int unsigned EN_HIGH_CYC    = 50,
  parameter int unsigned CMD_WAIT_CYC   = 5000,
  parameter int unsigned CLEAR_WAIT_CYC = 200_000
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [23:0] TIME_BCD,
  input  logic        TIME_VALID,
  output logic        READY,
  output logic        LCM_RS,
  output logic        LCM_RW,
  output logic        LCM_EN,
  output logic [7:0]  LCM_DATA
);

  localparam int             PU_W     = $clog2(POWERUP_CYC + 1);
  localparam logic [PU_W-1:0] PU_LAST = PU_W'(POWERUP_CYC - 1);
  localparam logic [4:0]     LAST_IDX = 5'd16;

  lcm_state_e      state_q, state_d;
  logic [4:0]      idx_q, idx_d;
  logic [PU_W-1:0] pu_cnt_q, pu_cnt_d;
  logic [23:0]     snap_q, snap_d, pend_bcd_q, pend_bcd_d, pend_val;
  logic            pend_q, pend_d, pend_any;
  logic            wr_start, wr_rs, wr_long, wr_busy, wr_done;
  logic [7:0]      wr_data;
  logic [3:0]      pos;

  // (state_q, idx_q) is the byte in flight; each launch moves to the next
  // position and issues it in the same cycle the previous byte reports done.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    pu_cnt_d   = pu_cnt_q;
    snap_d     = snap_q;
    pend_d     = pend_q;
    pend_bcd_d = pend_bcd_q;
    wr_start   = 1'b0;
    pend_any   = pend_q | TIME_VALID;
    pend_val   = TIME_VALID ? TIME_BCD : pend_bcd_q;
    if (TIME_VALID && (state_q != ST_IDLE)) begin
      pend_d     = 1'b1;
      pend_bcd_d = TIME_BCD;
    end
    case (state_q)
      ST_POWERUP:
        if (pu_cnt_q == PU_LAST && !wr_busy) begin
          wr_start = 1'b1;
          state_d  = ST_INIT;
          idx_d    = 5'd0;
        end else pu_cnt_d = pu_cnt_q + PU_W'(1);
      ST_INIT:
        if (wr_done) begin
          wr_start = 1'b1;
          if (idx_q == 5'd3) begin
            state_d = ST_BANNER;
            idx_d   = 5'd0;
          end else idx_d = idx_q + 5'd1;
        end
      ST_BANNER:
        if (wr_done) begin
          wr_start = 1'b1;
          if (idx_q == LAST_IDX) begin
            state_d = ST_LINE2;
            idx_d   = 5'd0;
            snap_d  = pend_any ? pend_val : 24'h000000;
            pend_d  = 1'b0;
          end else idx_d = idx_q + 5'd1;
        end
      ST_LINE2:
        if (wr_done) begin
          if (idx_q != LAST_IDX) begin
            wr_start = 1'b1;
            idx_d    = idx_q + 5'd1;
          end else if (pend_any) begin
            wr_start = 1'b1;
            idx_d    = 5'd0;
            snap_d   = pend_val;
            pend_d   = 1'b0;
          end else state_d = ST_IDLE;
        end
      ST_IDLE:
        if (TIME_VALID && !wr_busy) begin
          wr_start = 1'b1;
          state_d  = ST_LINE2;
          idx_d    = 5'd0;
          snap_d   = TIME_BCD;
        end
      default: state_d = ST_POWERUP;
    endcase
  end

  // Byte content for the position being launched; digits read the frozen snapshot.
  always_comb begin
    wr_rs   = 1'b0;
    wr_data = 8'h00;
    pos     = 4'(idx_d - 5'd1);
    case (state_d)
      ST_INIT: wr_data = INIT_CMDS[idx_d[1:0]];
      ST_BANNER:
        if (idx_d == 5'd0) wr_data = CMD_LINE1;
        else begin
          wr_rs   = 1'b1;
          wr_data = BANNER[pos];
        end
      ST_LINE2:
        if (idx_d == 5'd0) wr_data = CMD_LINE2;
        else begin
          wr_rs   = 1'b1;
          wr_data = line2_char(pos, snap_q);
        end
      default: ;
    endcase
    wr_long = !wr_rs && (wr_data == CMD_CLEAR);
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q    <= ST_POWERUP;
      idx_q      <= 5'd0;
      pu_cnt_q   <= '0;
      snap_q     <= 24'h000000;
      pend_q     <= 1'b0;
      pend_bcd_q <= 24'h000000;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      pu_cnt_q   <= pu_cnt_d;
      snap_q     <= snap_d;
      pend_q     <= pend_d;
      pend_bcd_q <= pend_bcd_d;
    end
  end

  lcm_byte_writer #(
    .SETUP_CYC     (SETUP_CYC),
    .EN_HIGH_CYC   (EN_HIGH_CYC),
    .CMD_WAIT_CYC  (CMD_WAIT_CYC),
    .CLEAR_WAIT_CYC(CLEAR_WAIT_CYC)
  ) u_writer (
    .CLK      (CLK),
    .RESET    (RESET),
    .start    (wr_start),
    .rs       (wr_rs),
    .data     (wr_data),
    .long_wait(wr_long),
    .busy     (wr_busy),
    .done     (wr_done),
    .LCM_RS   (LCM_RS),
    .LCM_EN   (LCM_EN),
    .LCM_DATA (LCM_DATA)
  );

  assign READY  = (state_q == ST_IDLE);
  assign LCM_RW = 1'b0;

endmodule
